// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: single-outstanding instruction-memory fetcher with a one-word
// hand-off buffer honouring hazard-unit stall/smash/redirect at hand-off.
module instruction_fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS = '0
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Enable,
  input  logic                     i_Stall,
  input  logic                     i_Smash,
  input  logic                     i_Load,
  input  logic [ADDRESS_WIDTH-1:0] i_Load_Address,
  output logic                     o_Mem_Valid,
  output logic [ADDRESS_WIDTH-1:0] o_Mem_Address,
  input  logic                     i_Mem_Ready,
  input  logic                     i_Mem_Valid,
  input  logic [DATA_WIDTH-1:0]    i_Mem_Data,
  output logic                     o_Done,
  output logic [DATA_WIDTH-1:0]    o_Instruction,
  output logic [ADDRESS_WIDTH-1:0] o_PC,
  output logic                     o_Instruction_Valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                   state, state_d;
  logic [ADDRESS_WIDTH-1:0] pc, pc_d, fetch_addr, fetch_addr_d;
  logic [ADDRESS_WIDTH-1:0] load_target, next_addr;
  logic [DATA_WIDTH-1:0]    instr, instr_d;
  logic                     mem_valid, done;
  logic [ADDRESS_WIDTH-1:0] mem_addr;

  // Redirect targets are word aligned; sequential fetch wraps naturally.
  assign load_target = i_Load_Address & ~ADDRESS_WIDTH'(3);
  assign next_addr   = i_Load ? load_target : fetch_addr + ADDRESS_WIDTH'(4);

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= S_IDLE;
      pc         <= START_ADDRESS;
      fetch_addr <= START_ADDRESS;
      instr      <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      fetch_addr <= fetch_addr_d;
      instr      <= instr_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    fetch_addr_d = fetch_addr;
    instr_d      = instr;
    mem_valid    = 1'b0;
    mem_addr     = pc;
    done         = 1'b0;
    case (state)
      S_IDLE: if (i_Enable) state_d = S_REQ;
      S_REQ: begin
        mem_valid = 1'b1;
        if (i_Mem_Ready) begin
          fetch_addr_d = pc;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_Mem_Valid) begin
          instr_d = i_Mem_Data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        done = 1'b1;
        // Hand-off: next request goes out in the same cycle the word leaves.
        if (!i_Stall) begin
          mem_valid = 1'b1;
          mem_addr  = next_addr;
          pc_d      = next_addr;
          if (i_Mem_Ready) begin
            fetch_addr_d = next_addr;
            state_d      = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_Mem_Valid         = mem_valid;
  assign o_Mem_Address       = mem_addr;
  assign o_Done              = done;
  assign o_Instruction       = instr;
  assign o_PC                = fetch_addr;
  assign o_Instruction_Valid = done & ~i_Smash;

endmodule
